// File: rtl/ex_alu_stage_if.sv
// Bundles the ID/EX operand/control inputs and the EX/MEM register outputs of the execute stage.
// The slave side is the execute stage itself; the master side is the pipeline around it.
interface ex_alu_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    // ID/EX side
    logic [5:0]    operation;
    logic          id_valid;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          alu_src;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [DW-1:0] mem_fwd;
    logic [DW-1:0] wb_fwd;
    logic [RW-1:0] rd_in;
    logic          regwrite_in;
    logic          memread_in;
    logic          memwrite_in;
    logic          branch_in;

    // EX/MEM side
    logic          exm_valid;
    logic [DW-1:0] exm_result;
    logic          exm_zero;
    logic [DW-1:0] exm_store_data;
    logic [RW-1:0] exm_rd;
    logic          exm_regwrite;
    logic          exm_memread;
    logic          exm_memwrite;
    logic          exm_branch;
    logic          exm_illegal;

    modport master (
        output operation, id_valid, rs_data, rt_data, imm, alu_src,
               fwd_a, fwd_b, mem_fwd, wb_fwd, rd_in,
               regwrite_in, memread_in, memwrite_in, branch_in,
        input  exm_valid, exm_result, exm_zero, exm_store_data, exm_rd,
               exm_regwrite, exm_memread, exm_memwrite, exm_branch, exm_illegal
    );

    modport slave (
        input  operation, id_valid, rs_data, rt_data, imm, alu_src,
               fwd_a, fwd_b, mem_fwd, wb_fwd, rd_in,
               regwrite_in, memread_in, memwrite_in, branch_in,
        output exm_valid, exm_result, exm_zero, exm_store_data, exm_rd,
               exm_regwrite, exm_memread, exm_memwrite, exm_branch, exm_illegal
    );
endinterface

// File: rtl/ex_alu_stage.sv
// Execute stage: forwarding muxes, ALU and the EX/MEM pipeline register; one-cycle latency.
// Stall holds the EX/MEM register, flush inserts a bubble (flush wins over stall, reset over both).
module ex_alu_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    ex_alu_stage_if.slave   bus
);
    localparam logic [5:0] OP_ADD = 6'd27;
    localparam logic [5:0] OP_SUB = 6'd28;
    localparam logic [5:0] OP_SRL = 6'd29;
    localparam logic [5:0] OP_SLL = 6'd30;
    localparam logic [5:0] OP_XOR = 6'd31;
    localparam logic [5:0] OP_AND = 6'd32;
    localparam logic [5:0] OP_SLT = 6'd33;
    localparam int         SHW    = $clog2(DW);

    // Encoding 2'b11 is reserved and falls back to the register value.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [1:0]    sel,
        input logic [DW-1:0] reg_v,
        input logic [DW-1:0] mem_v,
        input logic [DW-1:0] wb_v
    );
        case (sel)
            2'b01:   return mem_v;
            2'b10:   return wb_v;
            default: return reg_v;
        endcase
    endfunction

    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_bf;
    logic [DW-1:0]  op_b;
    logic [SHW-1:0] shamt;
    logic [DW-1:0]  alu_res;
    logic           op_legal;
    logic           ctl_ok;

    logic          valid_q,    valid_d;
    logic [DW-1:0] result_q,   result_d;
    logic          zero_q,     zero_d;
    logic [DW-1:0] store_q,    store_d;
    logic [RW-1:0] rd_q,       rd_d;
    logic          regwrite_q, regwrite_d;
    logic          memread_q,  memread_d;
    logic          memwrite_q, memwrite_d;
    logic          branch_q,   branch_d;
    logic          illegal_q,  illegal_d;

    always_comb begin
        op_a  = fwd_sel(bus.fwd_a, bus.rs_data, bus.mem_fwd, bus.wb_fwd);
        op_bf = fwd_sel(bus.fwd_b, bus.rt_data, bus.mem_fwd, bus.wb_fwd);
        op_b  = bus.alu_src ? bus.imm : op_bf;
        shamt = op_b[SHW-1:0];
    end

    always_comb begin
        alu_res  = '0;
        op_legal = 1'b1;
        case (bus.operation)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SLL:  alu_res = op_a << shamt;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: op_legal = 1'b0;
        endcase
    end

    // Control side effects are only allowed for a real instruction with a legal op.
    assign ctl_ok = bus.id_valid & op_legal;

    always_comb begin
        valid_d    = valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        store_d    = store_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        branch_d   = branch_q;
        illegal_d  = illegal_q;
        if (flush) begin
            valid_d    = 1'b0;
            result_d   = '0;
            zero_d     = 1'b0;
            store_d    = '0;
            rd_d       = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            branch_d   = 1'b0;
            illegal_d  = 1'b0;
        end else if (!stall) begin
            valid_d    = bus.id_valid;
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            store_d    = op_bf;
            rd_d       = bus.rd_in;
            regwrite_d = ctl_ok & bus.regwrite_in;
            memread_d  = ctl_ok & bus.memread_in;
            memwrite_d = ctl_ok & bus.memwrite_in;
            branch_d   = ctl_ok & bus.branch_in;
            illegal_d  = bus.id_valid & ~op_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            store_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            branch_q   <= branch_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.exm_valid      = valid_q;
    assign bus.exm_result     = result_q;
    assign bus.exm_zero       = zero_q;
    assign bus.exm_store_data = store_q;
    assign bus.exm_rd         = rd_q;
    assign bus.exm_regwrite   = regwrite_q;
    assign bus.exm_memread    = memread_q;
    assign bus.exm_memwrite   = memwrite_q;
    assign bus.exm_branch     = branch_q;
    assign bus.exm_illegal    = illegal_q;
endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed vectors for the execute stage; expectations are queued per edge and checked by a monitor.
module tb_ex_alu_stage;
    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;

    ex_alu_stage_if #(.DW(32), .RW(5)) bus ();

    ex_alu_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ctl packs {regwrite, memread, memwrite, branch}
    typedef struct {
        string       name;
        logic        v;
        logic [31:0] res;
        logic        z;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_pop++;
            chk(e.name, "valid",    {31'b0, bus.exm_valid},    {31'b0, e.v});
            chk(e.name, "result",   bus.exm_result,            e.res);
            chk(e.name, "zero",     {31'b0, bus.exm_zero},     {31'b0, e.z});
            chk(e.name, "store",    bus.exm_store_data,        e.sd);
            chk(e.name, "rd",       {27'b0, bus.exm_rd},       {27'b0, e.rd});
            chk(e.name, "ctl",      {28'b0, bus.exm_regwrite, bus.exm_memread, bus.exm_memwrite, bus.exm_branch},
                                    {28'b0, e.ctl});
            chk(e.name, "illegal",  {31'b0, bus.exm_illegal},  {31'b0, e.ill});
        end
    end

    task automatic drv(input logic [5:0] op, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic src, input logic [4:0] rd, input logic [3:0] ctl);
        bus.operation   = op;
        bus.id_valid    = v;
        bus.rs_data     = a;
        bus.rt_data     = b;
        bus.imm         = im;
        bus.alu_src     = src;
        bus.fwd_a       = 2'b00;
        bus.fwd_b       = 2'b00;
        bus.mem_fwd     = 32'hDEAD_0001;
        bus.wb_fwd      = 32'hDEAD_0002;
        bus.rd_in       = rd;
        bus.regwrite_in = ctl[3];
        bus.memread_in  = ctl[2];
        bus.memwrite_in = ctl[1];
        bus.branch_in   = ctl[0];
    endtask

    task automatic fwd(input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] mf, input logic [31:0] wf);
        bus.fwd_a   = fa;
        bus.fwd_b   = fb;
        bus.mem_fwd = mf;
        bus.wb_fwd  = wf;
    endtask

    task automatic expect_next(input string nm, input logic v, input logic [31:0] res, input logic z,
                               input logic [31:0] sd, input logic [4:0] rd, input logic [3:0] ctl,
                               input logic ill);
        exp_t e;
        @(posedge clk);
        e.name = nm; e.v = v; e.res = res; e.z = z; e.sd = sd; e.rd = rd; e.ctl = ctl; e.ill = ill;
        sb_q.push_back(e);
        n_push++;
        @(negedge clk);
    endtask

    localparam logic [5:0] ADD = 6'd27, SUB = 6'd28, SRL = 6'd29, SLL = 6'd30,
                           XOR = 6'd31, AND = 6'd32, SLT = 6'd33;

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drv(ADD, 1'b1, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 4'b1111);
        expect_next("rst_c1", 0, 32'h0, 0, 32'h0, 5'd0, 4'b0000, 0);
        stall = 1'b1;
        expect_next("rst_c2", 0, 32'h0, 0, 32'h0, 5'd0, 4'b0000, 0);
        rst = 1'b0; stall = 1'b0;
        drv(ADD, 1'b1, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 4'b1000);
        expect_next("add_first", 1, 32'd12, 0, 32'd7, 5'd3, 4'b1000, 0);

        drv(ADD, 1'b1, 32'hF0F0_0004, 32'd2, 32'd0, 1'b0, 5'd5, 4'b1000);
        expect_next("sw_add", 1, 32'hF0F0_0006, 0, 32'd2, 5'd5, 4'b1000, 0);
        bus.operation = SUB;
        expect_next("sw_sub", 1, 32'hF0F0_0002, 0, 32'd2, 5'd5, 4'b1000, 0);
        bus.operation = SRL;
        expect_next("sw_srl", 1, 32'h3C3C_0001, 0, 32'd2, 5'd5, 4'b1000, 0);
        bus.operation = SLL;
        expect_next("sw_sll", 1, 32'hC3C0_0010, 0, 32'd2, 5'd5, 4'b1000, 0);
        bus.operation = XOR;
        expect_next("sw_xor", 1, 32'hF0F0_0006, 0, 32'd2, 5'd5, 4'b1000, 0);
        bus.operation = AND;
        expect_next("sw_and", 1, 32'h0, 1, 32'd2, 5'd5, 4'b1000, 0);
        bus.operation = SLT;
        expect_next("sw_slt", 1, 32'h1, 0, 32'd2, 5'd5, 4'b1000, 0);

        drv(SUB, 1'b1, 32'h1234, 32'h1234, 32'd0, 1'b0, 5'd0, 4'b0001);
        expect_next("br_eq", 1, 32'h0, 1, 32'h1234, 5'd0, 4'b0001, 0);
        drv(SUB, 1'b1, 32'h1234, 32'h1235, 32'd0, 1'b0, 5'd0, 4'b0001);
        expect_next("br_ne", 1, 32'hFFFF_FFFF, 0, 32'h1235, 5'd0, 4'b0001, 0);

        drv(ADD, 1'b1, 32'd55, 32'd77, 32'd0, 1'b0, 5'd9, 4'b1000);
        fwd(2'b01, 2'b10, 32'd100, 32'd3);
        expect_next("fwd_add", 1, 32'd103, 0, 32'd3, 5'd9, 4'b1000, 0);
        drv(ADD, 1'b1, 32'd55, 32'd77, 32'hFFFF_FFFC, 1'b1, 5'd9, 4'b0100);
        fwd(2'b01, 2'b10, 32'd100, 32'd3);
        expect_next("fwd_imm", 1, 32'd96, 0, 32'd3, 5'd9, 4'b0100, 0);
        drv(ADD, 1'b1, 32'd55, 32'd77, 32'd8, 1'b1, 5'd0, 4'b0010);
        fwd(2'b10, 2'b01, 32'd100, 32'd3);
        expect_next("fwd_swap", 1, 32'd11, 0, 32'd100, 5'd0, 4'b0010, 0);
        drv(SUB, 1'b1, 32'd10, 32'd4, 32'd0, 1'b0, 5'd2, 4'b1000);
        fwd(2'b11, 2'b11, 32'd100, 32'd3);
        expect_next("fwd_rsvd", 1, 32'd6, 0, 32'd4, 5'd2, 4'b1000, 0);

        drv(SLL, 1'b1, 32'd1, 32'h21, 32'd0, 1'b0, 5'd1, 4'b1000);
        expect_next("sll_wrap", 1, 32'd2, 0, 32'h21, 5'd1, 4'b1000, 0);
        drv(SRL, 1'b1, 32'h8000_0001, 32'h20, 32'd0, 1'b0, 5'd1, 4'b1000);
        expect_next("srl_zero", 1, 32'h8000_0001, 0, 32'h20, 5'd1, 4'b1000, 0);
        drv(SLT, 1'b1, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd1, 4'b1000);
        expect_next("slt_false", 1, 32'h0, 1, 32'hFFFF_FFFF, 5'd1, 4'b1000, 0);

        drv(ADD, 1'b1, 32'd4, 32'd5, 32'd0, 1'b0, 5'd7, 4'b1000);
        expect_next("stl_load", 1, 32'd9, 0, 32'd5, 5'd7, 4'b1000, 0);
        stall = 1'b1;
        drv(SUB, 1'b1, 32'd100, 32'd1, 32'd0, 1'b0, 5'd12, 4'b0110);
        for (int i = 0; i < 3; i++)
            expect_next("stl_hold", 1, 32'd9, 0, 32'd5, 5'd7, 4'b1000, 0);
        flush = 1'b1;
        expect_next("fl_stall", 0, 32'h0, 0, 32'h0, 5'd0, 4'b0000, 0);
        stall = 1'b0;
        expect_next("fl_only", 0, 32'h0, 0, 32'h0, 5'd0, 4'b0000, 0);
        flush = 1'b0;
        expect_next("fl_resume", 1, 32'd99, 0, 32'd1, 5'd12, 4'b0110, 0);

        drv(6'd0, 1'b1, 32'd5, 32'd7, 32'd0, 1'b0, 5'd4, 4'b1000);
        expect_next("ill_op0", 1, 32'h0, 1, 32'd7, 5'd4, 4'b0000, 1);
        drv(6'd26, 1'b1, 32'd5, 32'd7, 32'd0, 1'b0, 5'd4, 4'b1011);
        expect_next("ill_op26", 1, 32'h0, 1, 32'd7, 5'd4, 4'b0000, 1);
        drv(6'd34, 1'b1, 32'd5, 32'd7, 32'd0, 1'b0, 5'd4, 4'b0110);
        expect_next("ill_op34", 1, 32'h0, 1, 32'd7, 5'd4, 4'b0000, 1);
        drv(6'd0, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd4, 4'b1000);
        expect_next("ill_novld", 0, 32'h0, 1, 32'd7, 5'd4, 4'b0000, 0);
        drv(ADD, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd6, 4'b1111);
        expect_next("novld_add", 0, 32'd2, 0, 32'd1, 5'd6, 4'b0000, 0);

        drv(ADD, 1'b1, 32'd1, 32'd2, 32'd0, 1'b0, 5'd8, 4'b1100);
        expect_next("pre_rst", 1, 32'd3, 0, 32'd2, 5'd8, 4'b1100, 0);
        rst = 1'b1; flush = 1'b1;
        expect_next("mid_rst", 0, 32'h0, 0, 32'h0, 5'd0, 4'b0000, 0);
        rst = 1'b0; flush = 1'b0;
        expect_next("post_rst", 1, 32'd3, 0, 32'd2, 5'd8, 4'b1100, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0 || n_pop != n_push) begin
            n_fail++;
            $display("FAIL drain: popped %0d of %0d expectations", n_pop, n_push);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute stage of the 5-stage pipelined CPU, sitting directly downstream of the ALU control decoder.
- Consumes the 6-bit operation code and the ID/EX operands, and applies EX/MEM-sourced and MEM/WB-sourced forwarding.
- Computes the ALU result and zero flag, and registers result, flags and passthrough control into the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- DW, 32, data path width.
- RW, 5, register index width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- operation  in  6  ALU op code from the ALU control decoder: 27 ADD, 28 SUB, 29 SRL, 30 SLL, 31 XOR, 32 AND, 33 SLT.
- id_valid  in  1  ID/EX slot holds a real instruction.
- rs_data  in  DW  operand A from ID/EX.
- rt_data  in  DW  operand B register value from ID/EX.
- imm  in  DW  sign-extended immediate.
- alu_src  in  1  1 selects imm as operand B.
- fwd_a  in  2  operand A source: 00 rs_data, 01 mem_fwd, 10 wb_fwd, 11 reserved (treated as 00).
- fwd_b  in  2  operand B register source, same encoding as fwd_a.
- mem_fwd  in  DW  EX/MEM result for forwarding.
- wb_fwd  in  DW  MEM/WB write data for forwarding.
- rd_in  in  RW  destination register index.
- regwrite_in  in  1  passthrough control.
- memread_in  in  1  passthrough control.
- memwrite_in  in  1  passthrough control.
- branch_in  in  1  passthrough control.
- stall  in  1  hold EX/MEM contents.
- flush  in  1  insert bubble.
- exm_valid  out  1  EX/MEM slot valid.
- exm_result  out  DW  registered ALU result.
- exm_zero  out  1  registered result==0.
- exm_store_data  out  DW  forwarded operand B register value (pre alu_src mux), for SW.
- exm_rd  out  RW  registered destination index.
- exm_regwrite  out  1  registered control.
- exm_memread  out  1  registered control.
- exm_memwrite  out  1  registered control.
- exm_branch  out  1  registered control.
- exm_illegal  out  1  registered: operation outside 27..33 on a valid instruction.

Behaviour:
- Latency: one cycle; inputs sampled at posedge drive exm_* after that edge.
- Operand path:
  - A = fwd_a-selected value.
  - Bf = fwd_b-selected value.
  - B = alu_src ? imm : Bf.
  - exm_store_data captures Bf.
- Arithmetic, modulo 2^DW with no overflow flag:
  - ADD: A+B.
  - SUB: A-B.
  - SRL: logical shift of A right by B[4:0].
  - SLL: logical shift of A left by B[4:0].
  - XOR: A^B.
  - AND: A&B.
  - SLT: signed compare, result {31'b0, A<B}.
  - Shift amount 0 returns A unchanged.
- Illegal op code (including 0, the decoder's reset value):
  - Result 0, zero=1.
  - exm_illegal=1 only if id_valid=1.
  - regwrite/memread/memwrite/branch forced to 0 in the registered copy.
- Zero flag is computed on the full DW-bit result.
- Priority per edge: rst > flush > stall > normal load.
- Reset: every exm_* output cleared to 0 (exm_valid=0, exm_zero=0, exm_illegal=0).
- Flush:
  - exm_valid, exm_regwrite, exm_memread, exm_memwrite, exm_branch, exm_illegal are cleared to 0.
  - Data fields are don't-care; they are cleared to 0 for determinism.
- Stall: all exm_* registers hold their current values. Flush with stall asserted together → flush wins.
- Normal load:
  - exm_valid = id_valid.
  - If id_valid=0, all control outputs are registered as 0 regardless of the *_in inputs.
- Reset mid-operation: the registered contents are discarded on that edge; no partial state remains.
- Combinational inputs are evaluated only at the edge; no outputs are combinational.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs → all exm_* = 0; release → first valid ADD 5+7 gives exm_result=12 after one edge.
- Op sweep, A=0xF0F0_0004, B=2 with alu_src=0:
  - ADD → 0xF0F0_0006.
  - SUB → 0xF0F0_0002.
  - SRL → 0x3C3C_0001.
  - SLL → 0xC3C0_0010.
  - XOR → 0xF0F0_0006.
  - AND → 0x0.
  - SLT → 1 (signed negative < 2).
- Branch: SUB with A=B=0x1234, branch_in=1 → exm_zero=1, exm_branch=1. Same with B=0x1235 → zero=0, result 0xFFFF_FFFF.
- Forwarding:
  - fwd_a=01, mem_fwd=100, fwd_b=10, wb_fwd=3, alu_src=0, ADD → 103.
  - With alu_src=1, imm=−4 → result 96, exm_store_data=3.
- Stall/flush:
  - Load ADD result 9, then stall=1 for 3 cycles with new inputs → outputs stay 9/valid.
  - flush=1 with stall=1 → exm_valid=0, regwrite=0.
- Illegal: operation=0, id_valid=1, regwrite_in=1 → exm_illegal=1, result 0, regwrite=0. Same with id_valid=0 → exm_illegal=0, exm_valid=0.
